// File: rtl/ssrv_mem_arbiter.sv
// ssrv_mem_arbiter
// Shares one single-port memory between an instruction port (imem, read-only)
// and a data port (dmem, read/write). The memory answers every request exactly
// one cycle after it is issued.
//
// Handshake: a port's req is sampled only when the port can take it, which is
// when the port is IDLE or in the cycle its resp is high. A request taken then
// is "accepted". Every accepted request gets exactly one resp strobe. err and
// rdata are valid only with resp. rdata is 0 whenever resp is 0.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   imem_req/addr       instruction read request
//   imem_resp/rdata/err instruction response
//   dmem_req/cmd/width/addr/wdata  data request (cmd 1 = write; width 0/1/2 = byte/half/word)
//   dmem_resp/rdata/err data response
//   mem_req/cmd/width/addr/wdata   request to shared memory (all zero when idle)
//   mem_resp/rdata      memory response, one cycle after mem_req
//
// Each port runs a small FSM: IDLE -> (PEND) -> WAIT -> IDLE/next. A request
// that loses arbitration parks in PEND and competes again every cycle. dmem has
// priority. imem wins once dmem has won STARVE_LIMIT times in a row while imem
// was waiting. Out-of-range addresses never reach memory. They are answered
// locally with err one cycle after acceptance.
module ssrv_mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int MEM_AW       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_req,
  input  logic [XLEN-1:0] imem_addr,
  output logic            imem_resp,
  output logic [XLEN-1:0] imem_rdata,
  output logic            imem_err,
  input  logic            dmem_req,
  input  logic            dmem_cmd,
  input  logic [1:0]      dmem_width,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  output logic [XLEN-1:0] dmem_rdata,
  output logic            dmem_resp,
  output logic            dmem_err,
  output logic            mem_req,
  output logic            mem_cmd,
  output logic [1:0]      mem_width,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_resp
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_WAIT = 2'd2
  } port_state_e;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  // Per-port FSM state and captured request fields
  port_state_e     i_state_q, i_state_d;
  port_state_e     d_state_q, d_state_d;
  logic [XLEN-1:0] i_addr_q, i_addr_d;
  logic [XLEN-1:0] d_addr_q, d_addr_d;
  logic [XLEN-1:0] d_wdata_q, d_wdata_d;
  logic            d_cmd_q, d_cmd_d;
  logic [1:0]      d_width_q, d_width_d;
  // A set err flag means the port is in WAIT for a locally generated error response
  logic            i_err_q, i_err_d;
  logic            d_err_q, d_err_d;

  // In-flight owner: id 1 = dmem, 0 = imem
  logic            own_v_q, own_v_d;
  logic            own_id_q, own_id_d;

  logic [3:0]      starve_q, starve_d;

  // Combinational helpers
  logic            i_mem_resp, d_mem_resp;
  logic            i_resp, d_resp;
  logic            i_acc, d_acc;
  logic            i_in_range, d_in_range;
  logic            i_pend, d_pend;
  logic            i_cand, d_cand;
  logic            grant_i, grant_d;
  logic            starve_hit;
  logic [XLEN-1:0] i_cand_addr, d_cand_addr, d_cand_wdata;
  logic            d_cand_cmd;
  logic [1:0]      d_cand_width;

  always_comb begin
    i_in_range = (imem_addr[XLEN-1:MEM_AW] == '0);
    d_in_range = (dmem_addr[XLEN-1:MEM_AW] == '0);

    // A memory response is only honoured for a recorded owner. Stale responses after reset fall out here.
    i_mem_resp = mem_resp & own_v_q & ~own_id_q;
    d_mem_resp = mem_resp & own_v_q &  own_id_q;
    i_resp     = i_mem_resp | i_err_q;
    d_resp     = d_mem_resp | d_err_q;

    // rst gates acceptance so no output can rise while in reset
    i_acc = rst & imem_req & ((i_state_q == ST_IDLE) | i_resp);
    d_acc = rst & dmem_req & ((d_state_q == ST_IDLE) | d_resp);

    // A parked entry outranks a live request on the same port
    i_pend       = (i_state_q == ST_PEND);
    d_pend       = (d_state_q == ST_PEND);
    i_cand       = i_pend | (i_acc & i_in_range);
    d_cand       = d_pend | (d_acc & d_in_range);
    i_cand_addr  = i_pend ? i_addr_q  : imem_addr;
    d_cand_addr  = d_pend ? d_addr_q  : dmem_addr;
    d_cand_wdata = d_pend ? d_wdata_q : dmem_wdata;
    d_cand_cmd   = d_pend ? d_cmd_q   : dmem_cmd;
    d_cand_width = d_pend ? d_width_q : dmem_width;

    starve_hit = (starve_q == STARVE_MAX);
    grant_d    = d_cand & ~(i_cand & starve_hit);
    grant_i    = i_cand & ~grant_d;
  end

  // Memory request mux (zero when nothing is issued)
  always_comb begin
    mem_req   = 1'b0;
    mem_cmd   = 1'b0;
    mem_width = 2'd0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_d) begin
      mem_req   = 1'b1;
      mem_cmd   = d_cand_cmd;
      mem_width = d_cand_width;
      mem_addr  = d_cand_addr;
      mem_wdata = d_cand_wdata;
    end else if (grant_i) begin
      mem_req   = 1'b1;
      mem_width = WIDTH_WORD;
      mem_addr  = i_cand_addr;
    end
  end

  // Response outputs
  always_comb begin
    imem_resp  = i_resp;
    imem_err   = i_err_q;
    imem_rdata = i_mem_resp ? mem_rdata : '0;
    dmem_resp  = d_resp;
    dmem_err   = d_err_q;
    dmem_rdata = d_mem_resp ? mem_rdata : '0;
  end

  // imem FSM next state
  always_comb begin
    i_state_d = i_state_q;
    i_addr_d  = i_addr_q;
    i_err_d   = 1'b0;
    if (i_acc) begin
      i_addr_d = imem_addr;
      if (!i_in_range) begin
        i_state_d = ST_WAIT;
        i_err_d   = 1'b1;
      end else if (grant_i) begin
        i_state_d = ST_WAIT;
      end else begin
        i_state_d = ST_PEND;
      end
    end else if (i_pend) begin
      if (grant_i) i_state_d = ST_WAIT;
    end else if (i_resp) begin
      i_state_d = ST_IDLE;
    end
  end

  // dmem FSM next state
  always_comb begin
    d_state_d = d_state_q;
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;
    d_cmd_d   = d_cmd_q;
    d_width_d = d_width_q;
    d_err_d   = 1'b0;
    if (d_acc) begin
      d_addr_d  = dmem_addr;
      d_wdata_d = dmem_wdata;
      d_cmd_d   = dmem_cmd;
      d_width_d = dmem_width;
      if (!d_in_range) begin
        d_state_d = ST_WAIT;
        d_err_d   = 1'b1;
      end else if (grant_d) begin
        d_state_d = ST_WAIT;
      end else begin
        d_state_d = ST_PEND;
      end
    end else if (d_pend) begin
      if (grant_d) d_state_d = ST_WAIT;
    end else if (d_resp) begin
      d_state_d = ST_IDLE;
    end
  end

  // Owner register and starvation counter
  always_comb begin
    own_v_d  = own_v_q;
    own_id_d = own_id_q;
    if (own_v_q && mem_resp) own_v_d = 1'b0;
    // A new issue in the response cycle replaces the retiring owner
    if (grant_d || grant_i) begin
      own_v_d  = 1'b1;
      own_id_d = grant_d;
    end

    starve_d = starve_q;
    if (!i_cand || grant_i) begin
      starve_d = 4'd0;
    end else if (grant_d && (starve_q != 4'hF)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_state_q <= ST_IDLE;
      d_state_q <= ST_IDLE;
      i_addr_q  <= '0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      d_cmd_q   <= 1'b0;
      d_width_q <= 2'd0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
      own_v_q   <= 1'b0;
      own_id_q  <= 1'b0;
      starve_q  <= 4'd0;
    end else begin
      i_state_q <= i_state_d;
      d_state_q <= d_state_d;
      i_addr_q  <= i_addr_d;
      d_addr_q  <= d_addr_d;
      d_wdata_q <= d_wdata_d;
      d_cmd_q   <= d_cmd_d;
      d_width_q <= d_width_d;
      i_err_q   <= i_err_d;
      d_err_q   <= d_err_d;
      own_v_q   <= own_v_d;
      own_id_q  <= own_id_d;
      starve_q  <= starve_d;
    end
  end

endmodule

// File: tb/tb_ssrv_mem_arbiter.sv
// Directed bench for ssrv_mem_arbiter. Inputs change 1 ns after each rising
// edge. Outputs are sampled 5 ns after the edge. The memory side is driven by
// hand per cycle.
module tb_ssrv_mem_arbiter;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_resp;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_err;
  logic            dmem_req;
  logic            dmem_cmd;
  logic [1:0]      dmem_width;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_resp;
  logic            dmem_err;
  logic            mem_req;
  logic            mem_cmd;
  logic [1:0]      mem_width;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_resp;

  int checks;
  int failures;

  ssrv_mem_arbiter #(.XLEN(32), .MEM_AW(16), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_resp  (imem_resp),
    .imem_rdata (imem_rdata),
    .imem_err   (imem_err),
    .dmem_req   (dmem_req),
    .dmem_cmd   (dmem_cmd),
    .dmem_width (dmem_width),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .dmem_err   (dmem_err),
    .mem_req    (mem_req),
    .mem_cmd    (mem_cmd),
    .mem_width  (mem_width),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Checking task
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req   = 1'b0;
    imem_addr  = '0;
    dmem_req   = 1'b0;
    dmem_cmd   = 1'b0;
    dmem_width = 2'd0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    mem_resp   = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic drive_d(input logic cmd, input logic [1:0] width,
                         input logic [31:0] addr, input logic [31:0] wdata);
    dmem_req   = 1'b1;
    dmem_cmd   = cmd;
    dmem_width = width;
    dmem_addr  = addr;
    dmem_wdata = wdata;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},    {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_addr"},   mem_addr, 32'd0);
    chk({tag, "_mem_wdata"},  mem_wdata, 32'd0);
    chk({tag, "_mem_cmdw"},   {29'd0, mem_cmd, mem_width}, 32'd0);
    chk({tag, "_imem_resp"},  {30'd0, imem_resp, imem_err}, 32'd0);
    chk({tag, "_dmem_resp"},  {30'd0, dmem_resp, dmem_err}, 32'd0);
    chk({tag, "_imem_rdata"}, imem_rdata, 32'd0);
    chk({tag, "_dmem_rdata"}, dmem_rdata, 32'd0);
  endtask

  // Scoreboard of expected mem_addr values for the starvation run
  logic [XLEN-1:0] exp_q[$];

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    idle_inputs();

    // Reset: outputs held at zero even with requests and mem_resp present
    tick();
    imem_req  = 1'b1;
    imem_addr = 32'h0000_0100;
    drive_d(1'b1, 2'd2, 32'h40, 32'hDEAD_BEEF);
    mem_resp  = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    #4;
    chk_all_zero("rst");
    chk("rst_istate", 32'(dut.i_state_q), 32'd0);
    chk("rst_starve", 32'(dut.starve_q), 32'd0);
    chk("rst_own_v",  {31'd0, dut.own_v_q}, 32'd0);
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();

    // imem alone: issue same cycle, response next cycle
    imem_req  = 1'b1;
    imem_addr = 32'h0000_0100;
    #4;
    chk("t1_mem_req",   {31'd0, mem_req}, 32'd1);
    chk("t1_mem_addr",  mem_addr, 32'h0000_0100);
    chk("t1_mem_cmdw",  {29'd0, mem_cmd, mem_width}, 32'd2);
    chk("t1_imem_resp", {31'd0, imem_resp}, 32'd0);
    tick();
    idle_inputs();
    mem_resp  = 1'b1;
    mem_rdata = 32'h1234_5678;
    #4;
    chk("t1_resp",       {30'd0, imem_resp, imem_err}, 32'd2);
    chk("t1_imem_rdata", imem_rdata, 32'h1234_5678);
    chk("t1_dmem_side",  {31'd0, dmem_resp}, 32'd0);
    chk("t1_dmem_rdata", dmem_rdata, 32'd0);
    chk("t1_mem_req2",   {31'd0, mem_req}, 32'd0);
    tick();
    idle_inputs();
    #4;
    chk("t1_idle_resp",  {31'd0, imem_resp}, 32'd0);
    chk("t1_idle_rdata", imem_rdata, 32'd0);
    tick();

    // Simultaneous requests: dmem write first, imem from PEND
    imem_req  = 1'b1;
    imem_addr = 32'h0000_0200;
    drive_d(1'b1, 2'd2, 32'h40, 32'hDEAD_BEEF);
    #4;
    chk("t2_c0_mem_req",   {31'd0, mem_req}, 32'd1);
    chk("t2_c0_mem_addr",  mem_addr, 32'h40);
    chk("t2_c0_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t2_c0_mem_cmdw",  {29'd0, mem_cmd, mem_width}, 32'h6);
    tick();
    idle_inputs();
    mem_resp = 1'b1;
    #4;
    chk("t2_c1_istate",    32'(dut.i_state_q), 32'd1);
    chk("t2_c1_dmem_resp", {30'd0, dmem_resp, dmem_err}, 32'd2);
    chk("t2_c1_imem_resp", {31'd0, imem_resp}, 32'd0);
    chk("t2_c1_mem_addr",  mem_addr, 32'h200);
    chk("t2_c1_mem_cmdw",  {29'd0, mem_cmd, mem_width}, 32'd2);
    chk("t2_c1_mem_wdata", mem_wdata, 32'd0);
    tick();
    mem_resp  = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    #4;
    chk("t2_c2_imem_resp",  {30'd0, imem_resp, imem_err}, 32'd2);
    chk("t2_c2_imem_rdata", imem_rdata, 32'hCAFE_0001);
    chk("t2_c2_dmem_resp",  {31'd0, dmem_resp}, 32'd0);
    chk("t2_c2_mem_req",    {31'd0, mem_req}, 32'd0);
    tick();
    idle_inputs();
    tick();

    // Starvation: four dmem grants, then imem, counter back to 0
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(32'h1000 + 32'(4 * k));
    exp_q.push_back(32'h300);
    exp_q.push_back(32'h1010);
    imem_req  = 1'b1;
    imem_addr = 32'h300;
    for (int c = 0; c < 6; c++) begin
      if (c < 5) drive_d(1'b0, 2'd2, 32'h1000 + 32'(4 * c), 32'd0);
      else dmem_req = 1'b0;
      if (c > 0) begin
        mem_resp  = 1'b1;
        mem_rdata = 32'h100 + 32'(c);
      end
      #4;
      chk($sformatf("t3_c%0d_mem_req", c), {31'd0, mem_req}, 32'd1);
      chk($sformatf("t3_c%0d_mem_addr", c), mem_addr, exp_q.pop_front());
      if (c >= 1 && c <= 4) begin
        chk($sformatf("t3_c%0d_dmem_rdata", c), dmem_rdata, 32'h100 + 32'(c));
        chk($sformatf("t3_c%0d_starve", c), 32'(dut.starve_q), 32'(c));
      end
      tick();
      imem_req = 1'b0;
    end
    // cycle 5 was checked above; cycle 6 carries the last dmem response
    mem_resp  = 1'b1;
    mem_rdata = 32'h77;
    #4;
    chk("t3_c6_dmem_resp",  {31'd0, dmem_resp}, 32'd1);
    chk("t3_c6_dmem_rdata", dmem_rdata, 32'h77);
    chk("t3_c6_mem_req",    {31'd0, mem_req}, 32'd0);
    chk("t3_c6_starve",     32'(dut.starve_q), 32'd0);
    tick();
    idle_inputs();
    tick();

    // Out-of-range dmem read: never reaches memory, error next cycle
    drive_d(1'b0, 2'd2, 32'h0001_0000, 32'd0);
    #4;
    chk("t4_c0_mem_req",   {31'd0, mem_req}, 32'd0);
    chk("t4_c0_dmem_resp", {31'd0, dmem_resp}, 32'd0);
    tick();
    idle_inputs();
    mem_rdata = 32'hFFFF_FFFF;
    #4;
    chk("t4_c1_dmem_resp",  {30'd0, dmem_resp, dmem_err}, 32'd3);
    chk("t4_c1_dmem_rdata", dmem_rdata, 32'd0);
    tick();
    idle_inputs();
    #4;
    chk("t4_c2_dmem_resp", {30'd0, dmem_resp, dmem_err}, 32'd0);
    tick();

    // Reset with imem PEND and dmem in flight
    imem_req  = 1'b1;
    imem_addr = 32'h600;
    drive_d(1'b0, 2'd2, 32'h44, 32'd0);
    #4;
    chk("t5_c0_mem_addr", mem_addr, 32'h44);
    #1;
    rst = 1'b0;
    #1;
    chk_all_zero("t5_in_rst");
    chk("t5_states", {28'd0, 2'(dut.i_state_q), 2'(dut.d_state_q)}, 32'd0);
    tick();
    idle_inputs();
    rst       = 1'b1;
    mem_resp  = 1'b1;
    mem_rdata = 32'h5555_5555;
    #4;
    chk_all_zero("t5_release");
    tick();
    idle_inputs();
    imem_req  = 1'b1;
    imem_addr = 32'h500;
    #4;
    chk("t5_next_mem_addr", mem_addr, 32'h500);
    tick();
    idle_inputs();
    mem_resp  = 1'b1;
    mem_rdata = 32'h0000_0BAD;
    #4;
    chk("t5_next_resp",  {30'd0, imem_resp, imem_err}, 32'd2);
    chk("t5_next_rdata", imem_rdata, 32'h0000_0BAD);
    tick();
    idle_inputs();
    tick();

    // Back-to-back dmem: new request accepted in the response cycle
    drive_d(1'b0, 2'd0, 32'h80, 32'd0);
    #4;
    chk("t6_c0_mem", {mem_addr[29:0], mem_width}, {30'h80, 2'd0});
    tick();
    drive_d(1'b0, 2'd1, 32'h84, 32'd0);
    mem_resp  = 1'b1;
    mem_rdata = 32'h11;
    #4;
    chk("t6_c1_dmem_rdata", dmem_rdata, 32'h11);
    chk("t6_c1_dmem_resp",  {31'd0, dmem_resp}, 32'd1);
    chk("t6_c1_mem",        {mem_addr[29:0], mem_width}, {30'h84, 2'd1});
    chk("t6_c1_mem_req",    {31'd0, mem_req}, 32'd1);
    tick();
    idle_inputs();
    mem_resp  = 1'b1;
    mem_rdata = 32'h22;
    #4;
    chk("t6_c2_dmem_rdata", dmem_rdata, 32'h22);
    chk("t6_c2_dmem_resp",  {31'd0, dmem_resp}, 32'd1);
    chk("t6_c2_mem_req",    {31'd0, mem_req}, 32'd0);
    tick();
    idle_inputs();
    #4;
    chk("t6_c3_dmem_resp", {31'd0, dmem_resp}, 32'd0);
    tick();

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
